// File: rtl/rca_pkg.sv
// Shared constants and types for the ripple-carry sum accumulator.
// State encoding, addend width and default build parameters.
package rca_pkg;

    localparam int ADDEND_W    = 5;
    localparam int DEF_SAMPLES = 4;
    localparam int DEF_ACC_W   = 8;

    typedef enum logic {
        RCA_ST_ACC  = 1'b0,
        RCA_ST_DONE = 1'b1
    } rca_state_e;

endpackage

// File: rtl/rca_acc_adder.sv
// Combinational accumulator + addend with carry-out detection.
// Clamps to all-ones on overflow when RCA_ACC_SAT_EN is defined.
module rca_acc_adder
    import rca_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]    acc_i,
    input  logic [ADDEND_W-1:0] addend_i,
    output logic [ACC_W-1:0]    sum_o,
    output logic                ovf_o
);

    logic [ACC_W:0] wide;

    // Widened add so the carry-out is the overflow indication
    always_comb begin
        wide  = {1'b0, acc_i} + {{(ACC_W + 1 - ADDEND_W){1'b0}}, addend_i};
        ovf_o = wide[ACC_W];
`ifdef RCA_ACC_SAT_EN
        sum_o = ovf_o ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
        sum_o = wide[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/rca_sum_accumulator.sv
// Accumulates SAMPLES adder results, presents total on valid/ready.
// Saturating overflow available via RCA_ACC_SAT_EN (default: wrap).
module rca_sum_accumulator
    import rca_pkg::*;
#(
    parameter int SAMPLES = DEF_SAMPLES,
    parameter int ACC_W   = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [3:0]       in_sum,
    input  logic             in_carry,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CNT_W = $clog2(SAMPLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES - 1);

    rca_state_e          state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;

    logic [ADDEND_W-1:0] addend;
    logic [ACC_W-1:0]    add_sum;
    logic                add_ovf;

    assign addend = {in_carry, in_sum};

    rca_acc_adder #(
        .ACC_W(ACC_W)
    ) u_adder (
        .acc_i   (acc_q),
        .addend_i(addend),
        .sum_o   (add_sum),
        .ovf_o   (add_ovf)
    );

    // Handshake flags come straight from the state register
    assign in_ready  = (state_q == RCA_ST_ACC);
    assign out_valid = (state_q == RCA_ST_DONE);
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;

    // Next-state: clr wins, then accept in ACC or handshake in DONE
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clr) begin
            state_d = RCA_ST_ACC;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                RCA_ST_ACC: begin
                    if (in_valid) begin
                        acc_d = add_sum;
                        ovf_d = ovf_q | add_ovf;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_d = RCA_ST_DONE;
                        end
                    end
                end
                RCA_ST_DONE: begin
                    if (out_ready) begin
                        state_d = RCA_ST_ACC;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = RCA_ST_ACC;
                end
            endcase
        end
    end

    // State, accumulator, counter and sticky overflow registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RCA_ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_rca_sum_accumulator.sv
// Bench for rca_sum_accumulator: three builds checked against an
// integer running-total model (define RCA_ACC_SAT_EN for saturating).
module tb_rca_sum_accumulator;

`ifdef RCA_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [3:0] in_sum;
    logic       in_carry;
    logic       in_valid;
    logic       out_ready;

    logic [2:0] rdy_o;
    logic [2:0] vld_o;
    logic [2:0] ovf_o;
    logic [7:0] acc_o0;
    logic [5:0] acc_o1;
    logic [7:0] acc_o2;

    int checks = 0;
    int fails  = 0;

    int tot_m [3];
    int n_m   [3];
    bit done_m[3];

    always #5 clk = ~clk;

    rca_sum_accumulator #(.SAMPLES(4), .ACC_W(8)) u0 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_sum(in_sum), .in_carry(in_carry), .in_valid(in_valid),
        .in_ready(rdy_o[0]), .out_acc(acc_o0), .out_ovf(ovf_o[0]),
        .out_valid(vld_o[0]), .out_ready(out_ready)
    );

    rca_sum_accumulator #(.SAMPLES(4), .ACC_W(6)) u1 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_sum(in_sum), .in_carry(in_carry), .in_valid(in_valid),
        .in_ready(rdy_o[1]), .out_acc(acc_o1), .out_ovf(ovf_o[1]),
        .out_valid(vld_o[1]), .out_ready(out_ready)
    );

    rca_sum_accumulator #(.SAMPLES(1), .ACC_W(8)) u2 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_sum(in_sum), .in_carry(in_carry), .in_valid(in_valid),
        .in_ready(rdy_o[2]), .out_acc(acc_o2), .out_ovf(ovf_o[2]),
        .out_valid(vld_o[2]), .out_ready(out_ready)
    );

    function automatic int samp(int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic int accw(int i);
        return (i == 1) ? 6 : 8;
    endfunction

    // Register content as a function of the exact running total
    function automatic logic [31:0] exp_acc(int t, int w);
        int m;
        m = 1 << w;
        if (SAT) return (t >= m) ? 32'(m - 1) : 32'(t);
        return 32'(t % m);
    endfunction

    function automatic logic [31:0] exp_ovf(int t, int w);
        return (t >= (1 << w)) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] dut_acc(int i);
        if (i == 0) return {24'd0, acc_o0};
        if (i == 1) return {26'd0, acc_o1};
        return {24'd0, acc_o2};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            tot_m[i]  = 0;
            n_m[i]    = 0;
            done_m[i] = 1'b0;
        end
    endtask

    // Apply the inputs present at this clock edge to every model
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (clr) begin
                tot_m[i] = 0; n_m[i] = 0; done_m[i] = 1'b0;
            end else if (done_m[i]) begin
                if (out_ready) begin
                    tot_m[i] = 0; n_m[i] = 0; done_m[i] = 1'b0;
                end
            end else if (in_valid) begin
                tot_m[i] += int'({in_carry, in_sum});
                n_m[i]++;
                if (n_m[i] == samp(i)) done_m[i] = 1'b1;
            end
        end
    endtask

    task automatic check_all(string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.u%0d.in_ready", tag, i),
                32'(rdy_o[i]), 32'(!done_m[i]));
            chk($sformatf("%s.u%0d.out_valid", tag, i),
                32'(vld_o[i]), 32'(done_m[i]));
            chk($sformatf("%s.u%0d.out_acc", tag, i),
                dut_acc(i), exp_acc(tot_m[i], accw(i)));
            chk($sformatf("%s.u%0d.out_ovf", tag, i),
                32'(ovf_o[i]), exp_ovf(tot_m[i], accw(i)));
        end
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic put(int s, int c);
        in_sum   = 4'(s);
        in_carry = 1'(c);
        in_valid = 1'b1;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_sum = '0; in_carry = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        model_reset();
        #3;
        check_all("reset");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic sum, consumer always ready
        out_ready = 1'b1;
        put(5, 0);  tick("basic");
        put(15, 1); tick("basic");
        put(3, 0);  tick("basic");
        put(0, 0);  tick("basic");
        chk("basic_valid", 32'(vld_o[0]), 32'd1);
        chk("basic_acc", {24'd0, acc_o0}, 32'd39);
        chk("basic_ovf", 32'(ovf_o[0]), 32'd0);
        in_valid = 1'b0;
        tick("basic_hs");
        chk("basic_hs_rdy", 32'(rdy_o[0]), 32'd1);
        chk("basic_hs_acc", {24'd0, acc_o0}, 32'd0);

        // Backpressure with a held in_valid
        out_ready = 1'b0;
        put(5, 0);  tick("bp");
        put(15, 1); tick("bp");
        put(3, 0);  tick("bp");
        put(0, 0);  tick("bp");
        put(9, 1);
        for (int k = 0; k < 5; k++) begin
            tick("bp_hold");
            chk("bp_hold_acc", {24'd0, acc_o0}, 32'd39);
            chk("bp_hold_rdy", 32'(rdy_o[0]), 32'd0);
        end
        out_ready = 1'b1;
        tick("bp_hs");
        chk("bp_hs_acc", {24'd0, acc_o0}, 32'd0);
        chk("bp_hs_rdy", 32'(rdy_o[0]), 32'd1);
        in_valid = 1'b0;
        tick("bp_idle");

        // Overflow: four addends of 31
        clr = 1'b1; tick("ovf_clr"); clr = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            put(15, 1); tick("ovf");
        end
        in_valid = 1'b0;
        chk("ovf_acc6", {26'd0, acc_o1}, SAT ? 32'd63 : 32'd60);
        chk("ovf_flag6", 32'(ovf_o[1]), 32'd1);
        chk("ovf_acc8", {24'd0, acc_o0}, 32'd124);
        out_ready = 1'b1;
        tick("ovf_hs");

        // clr collides with an accept
        clr = 1'b1; tick("clr_pre"); clr = 1'b0;
        out_ready = 1'b0;
        put(5, 0); tick("clr_a");
        put(5, 0); tick("clr_a");
        chk("clr_pre_acc", {24'd0, acc_o0}, 32'd10);
        put(7, 0); clr = 1'b1; tick("clr_hit"); clr = 1'b0;
        chk("clr_hit_acc", {24'd0, acc_o0}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            put(k + 1, 0); tick("clr_refill");
        end
        chk("clr_not_done", 32'(vld_o[0]), 32'd0);
        put(4, 0); tick("clr_refill");
        chk("clr_done", 32'(vld_o[0]), 32'd1);
        chk("clr_done_acc", {24'd0, acc_o0}, 32'd10);
        in_valid = 1'b0; out_ready = 1'b1;
        tick("clr_hs");

        // SAMPLES=1 build with alternating stalls
        clr = 1'b1; tick("s1_clr"); clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            out_ready = 1'(k);
            put(1, 1); tick("s1_acc");
            in_valid = 1'b0;
            chk("s1_valid", 32'(vld_o[2]), 32'd1);
            chk("s1_acc", {24'd0, acc_o2}, 32'd17);
            if (k[0] == 1'b0) begin
                tick("s1_stall");
                out_ready = 1'b1;
            end
            tick("s1_hs");
            chk("s1_back", 32'(rdy_o[2]), 32'd1);
        end

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sum    = 4'($urandom);
            in_carry  = 1'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            clr       = ($urandom_range(0, 15) == 0);
            tick("rand");
        end
        clr = 1'b0;

        // Asynchronous reset while holding a result
        clr = 1'b1; tick("ar_clr"); clr = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            put(15, 1); tick("ar_fill");
        end
        in_valid = 1'b0;
        tick("ar_hold");
        chk("ar_pre_valid", 32'(vld_o[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("ar_async");
        chk("ar_valid", 32'(vld_o[0]), 32'd0);
        chk("ar_acc", {24'd0, acc_o0}, 32'd0);
        #1;
        rst = 1'b0;
        #1;
        check_all("ar_release");
        put(2, 0);
        tick("ar_after");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/rca_sum_accumulator.md
Name: rca_sum_accumulator

Overview:
- Downstream consumer of the 4-bit ripple-carry adder stage.
- Takes the adder's registered-in 4-bit sum plus carry-out as one 5-bit addend.
- Accumulates SAMPLES addends into an ACC_W-bit register, then presents the total with an overflow flag on a valid/ready output handshake.
- Sits between the adder datapath and any result consumer (display, checker, next arithmetic stage).

Parameters:
- SAMPLES, 4, number of accepted addends per result; legal range 1..255.
- ACC_W, 8, accumulator width in bits; must be >= 5.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- clr  input  1  synchronous abort: empties accumulator, count and flag.
- in_sum  input  4  adder sum output.
- in_carry  input  1  adder carry output.
- in_valid  input  1  addend present.
- in_ready  output  1  block can accept an addend.
- out_acc  output  ACC_W  accumulated result.
- out_ovf  output  1  result overflowed (wrapped or saturated) at least once.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.

Behaviour:
- Interface: one clock (clk); rst is asynchronous, active-high.
- Reset (asserted at any time, including mid-accumulation or mid-DONE):
  - Outputs take these values immediately: state=ACC, acc=0, cnt=0, ovf=0, out_valid=0, in_ready=1.
  - out_acc=0 and out_ovf=0.
- States:
  - ACC: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Addend and accept rule:
  - Addend = zero-extended {in_carry,in_sum}, range 0..31.
  - Accept = in_valid && in_ready.
  - On accept: acc <= acc + addend, cnt <= cnt + 1.
- Overflow:
  - Overflow occurs when the ACC_W-bit sum carries out.
  - Without the optional feature, acc wraps modulo 2^ACC_W and ovf <= 1 (sticky).
- ACC -> DONE:
  - Transition on the accept that makes cnt == SAMPLES.
  - out_valid rises the cycle after that accept (1-cycle latency).
  - out_acc includes the final addend.
- DONE hold:
  - out_acc and out_ovf are held stable until out_valid && out_ready.
  - in_valid is ignored while in_ready=0; the upstream source must hold its data.
- DONE -> ACC:
  - Occurs on handshake.
  - Next cycle: acc=0, cnt=0, ovf=0, in_ready=1.
  - No same-cycle accept of a new addend during the handshake cycle.
- out_acc / out_ovf are driven from the registers in both states (visible while accumulating). They are meaningful only when out_valid=1.
- clr:
  - In either state: next cycle acc=0, cnt=0, ovf=0, state=ACC.
  - clr beats a simultaneous accept; that addend is dropped.
  - clr beats a simultaneous out handshake; the result is discarded.
- SAMPLES=1: every accept goes straight to DONE.
- cnt width: $clog2(SAMPLES+1).
- No combinational path from inputs to in_ready or out_valid.

Optional Feature:
- Macro: RCA_ACC_SAT_EN.
- Defined: on overflow, acc clamps to all-ones (2^ACC_W-1) and ovf <= 1. Further accepts keep it clamped.
- Undefined: modulo wrap as above; ovf still set.
- The handshake and timing are identical in both builds.

Decomposition:
- Shared package/include rca_pkg:
  - State encoding constants RCA_ST_ACC=1'b0, RCA_ST_DONE=1'b1.
  - ADDEND_W=5.
  - Default SAMPLES and ACC_W constants.
- One sub-module, rca_acc_adder:
  - Purely combinational ACC_W-bit add of the accumulator and the zero-extended addend.
  - Outputs: the next value and an overflow bit.
  - Holds the RCA_ACC_SAT_EN clamp logic.
- The top holds the FSM, counter, registers and handshake.

Test Plan:
- Basic sum (SAMPLES=4, ACC_W=8): accept (5,c0),(15,c1),(3,c0),(0,c0) back-to-back with out_ready=1 -> out_valid one cycle after the 4th accept, out_acc=0x27 (39), out_ovf=0. Next cycle in_ready=1 and acc=0.
- Backpressure: same stream, out_ready=0 for 5 cycles -> out_valid=1, out_acc=39, in_ready=0 held all 5 cycles. A held in_valid is not consumed. Then out_ready=1 -> one handshake, then back to ACC.
- Overflow (ACC_W=6), four addends of 31:
  - Wrap build -> out_acc=60, out_ovf=1.
  - RCA_ACC_SAT_EN build -> out_acc=63, out_ovf=1.
- clr collision: after 2 accepts (acc=10), assert clr with in_valid=1 (addend 7) -> next cycle acc=0, cnt=0. The addend is lost; a further 4 accepts are needed for a result.
- Async reset in DONE: assert rst between clock edges while out_valid=1 -> out_valid=0, out_acc=0, out_ovf=0 before the next edge. in_ready=1 after release.
- SAMPLES=1: accept addend 17 -> out_valid next cycle with out_acc=17. The handshake returns to ACC. Repeat 3 times with alternating out_ready stalls.
